// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state, opcode and datapath select encodings for the multi-cycle controller
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST     = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_MEMADDR = 4'd3,
    ST_MEMRD   = 4'd4,
    ST_MEMWB   = 4'd5,
    ST_MEMWR   = 4'd6,
    ST_REXEC   = 4'd7,
    ST_RWB     = 4'd8,
    ST_IEXEC   = 4'd9,
    ST_IWB     = 4'd10,
    ST_BRANCH  = 4'd11,
    ST_JUMP    = 4'd12,
    ST_ILLEGAL = 4'd13,
    ST_HALT    = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Dispatch out of DECODE; anything not recognised traps to ILLEGAL.
  function automatic state_e decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: decode_next = ST_MEMADDR;
      OP_RTYPE:     decode_next = ST_REXEC;
      OP_ADDI:      decode_next = ST_IEXEC;
      OP_BEQ:       decode_next = ST_BRANCH;
      OP_J:         decode_next = ST_JUMP;
      OP_HALT:      decode_next = ST_HALT;
      default:      decode_next = ST_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS controller FSM with retired-instruction counter
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             irwrite,
  output logic             alusrca,
  output logic             regwrite,
  output logic             regdst,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             retire,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_count_q, retired_count_d;

  // State register; reset lands in RST so every output is 0 immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode; only FETCH/MEMWR outputs look at mem_ready.
  always_comb begin
    state_d     = state_q;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    irwrite     = 1'b0;
    alusrca     = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    alusrcb     = SRCB_B;
    aluop       = ALUOP_ADD;
    pcsource    = PCSRC_ALU;
    retire      = 1'b0;
    illegal     = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        state_d = mem_ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        alusrcb = SRCB_IMM_SH2;
        state_d = decode_next(opcode);
      end
      ST_MEMADDR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
      end
      ST_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        retire   = mem_ready;
        state_d  = mem_ready ? ST_FETCH : ST_MEMWR;
      end
      ST_REXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_B;
        aluop   = ALUOP_FUNCT;
        state_d = ST_RWB;
      end
      ST_RWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = ST_IWB;
      end
      ST_IWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_BRANCH: begin
        alusrca     = 1'b1;
        alusrcb     = SRCB_B;
        aluop       = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsource    = PCSRC_ALUOUT;
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = PCSRC_JUMP;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_ILLEGAL: begin
        illegal = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        halted  = 1'b1;
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // Retire counter next value; wraps naturally at 2^CNT_W.
  always_comb begin
    retired_count_d = retired_count_q;
    if (retire) begin
      retired_count_d = retired_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Retire counter register, cleared asynchronously with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count_q <= '0;
    end else begin
      retired_count_q <= retired_count_d;
    end
  end

  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        mem_ready = 1'b0;

  logic        pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite;
  logic        alusrca, regwrite, regdst, retire, illegal, halted;
  logic [1:0]  alusrcb, aluop, pcsource;
  logic [31:0] retired_count;

  logic        s_pcwrite, s_pcwritecond, s_iord, s_memread, s_memwrite, s_memtoreg, s_irwrite;
  logic        s_alusrca, s_regwrite, s_regdst, s_retire, s_illegal, s_halted;
  logic [1:0]  s_alusrcb, s_aluop, s_pcsource;
  logic [2:0]  s_retired_count;

  int checks = 0;
  int errors = 0;
  longint exp_count = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .irwrite(irwrite), .alusrca(alusrca),
    .regwrite(regwrite), .regdst(regdst), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .retire(retire), .illegal(illegal), .halted(halted),
    .retired_count(retired_count)
  );

  // Narrow-counter copy driven identically, so counter wrap is reached quickly.
  multicycle_ctrl #(.CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(s_pcwrite), .pcwritecond(s_pcwritecond), .iord(s_iord), .memread(s_memread),
    .memwrite(s_memwrite), .memtoreg(s_memtoreg), .irwrite(s_irwrite), .alusrca(s_alusrca),
    .regwrite(s_regwrite), .regdst(s_regdst), .alusrcb(s_alusrcb), .aluop(s_aluop),
    .pcsource(s_pcsource), .retire(s_retire), .illegal(s_illegal), .halted(s_halted),
    .retired_count(s_retired_count)
  );

  typedef struct {
    int cycles;
    int timeout;
    int n_retire;
    int n_illegal;
    int n_irwrite;
    int stall_err;
    int saw_regwrite;
    int saw_memwrite;
    int saw_memtoreg;
    int saw_rd;
    int saw_branch;
    int saw_jump;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    int         sf;
    int         sm;
    int         exp_cycles;
    string      name;
  } vec_t;

  function automatic logic [18:0] outvec();
    return {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca,
            regwrite, regdst, alusrcb, aluop, pcsource, retire, illegal, halted};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Minimum instruction length from the timing rules; illegal is FETCH+DECODE+ILLEGAL.
  function automatic int base_cycles(input logic [5:0] op);
    case (op)
      OP_LW:                      return 5;
      OP_SW, OP_RTYPE, OP_ADDI:   return 4;
      OP_BEQ, OP_J:               return 3;
      default:                    return 3;
    endcase
  endfunction

  // Entered at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH.
  // mem_ready is low for sf cycles from FETCH and for sm cycles from the first memory-access cycle.
  task automatic run_instr(input logic [5:0] op, input int sf, input int sm, output obs_t o);
    int k;
    bit done;
    logic [18:0] cur, prev;
    o = '{default: 0};
    opcode = op;
    k = 0;
    done = 0;
    prev = '0;
    while (!done && k < 64) begin
      mem_ready = !((k < sf) || (k >= sf + 3 && k < sf + 3 + sm));
      #1;
      cur = outvec();
      if (k < sf && memread !== 1'b1) o.stall_err++;
      if (k >= 1 && k < sf && cur !== prev) o.stall_err++;
      if (is_mem(op) && k >= sf + 3 && k < sf + 3 + sm) begin
        if (op == OP_LW && memread !== 1'b1) o.stall_err++;
        if (op == OP_SW && memwrite !== 1'b1) o.stall_err++;
        if (k > sf + 3 && cur !== prev) o.stall_err++;
      end
      if (irwrite)  o.n_irwrite++;
      if (retire)   o.n_retire++;
      if (illegal)  o.n_illegal++;
      if (regwrite) o.saw_regwrite = 1;
      if (memwrite) o.saw_memwrite = 1;
      if (memtoreg && regwrite) o.saw_memtoreg = 1;
      if (regdst && regwrite) o.saw_rd = 1;
      if (pcwritecond && pcsource == 2'b01) o.saw_branch = 1;
      if (pcwrite && pcsource == 2'b10) o.saw_jump = 1;
      if (retire || illegal) done = 1;
      prev = cur;
      k++;
      @(posedge clk);
      #1;
    end
    o.cycles = k;
    o.timeout = done ? 0 : 1;
  endtask

  task automatic verify(input string name, input logic [5:0] op, input obs_t o, input int exp_cycles);
    bit legal;
    legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
            (op == OP_ADDI) || (op == OP_BEQ) || (op == OP_J);
    if (legal) exp_count++;
    chk({name, " timeout"},   o.timeout, 0);
    chk({name, " cycles"},    o.cycles, exp_cycles);
    chk({name, " irwrite"},   o.n_irwrite, 1);
    chk({name, " stall"},     o.stall_err, 0);
    chk({name, " retire"},    o.n_retire, legal ? 1 : 0);
    chk({name, " illegal"},   o.n_illegal, legal ? 0 : 1);
    chk({name, " regwrite"},  o.saw_regwrite,
        (op == OP_RTYPE || op == OP_ADDI || op == OP_LW) ? 1 : 0);
    chk({name, " memwrite"},  o.saw_memwrite, (op == OP_SW) ? 1 : 0);
    chk({name, " memtoreg"},  o.saw_memtoreg, (op == OP_LW) ? 1 : 0);
    chk({name, " regdst"},    o.saw_rd, (op == OP_RTYPE) ? 1 : 0);
    chk({name, " pcsrc01"},   o.saw_branch, (op == OP_BEQ) ? 1 : 0);
    chk({name, " pcsrc10"},   o.saw_jump, (op == OP_J) ? 1 : 0);
    chk({name, " count"},     retired_count, exp_count & 64'hFFFF_FFFF);
    chk({name, " count3"},    s_retired_count, exp_count % 8);
  endtask

  vec_t vecs[$];
  obs_t o;

  initial begin
    logic [5:0] legal_ops[6];
    logic [5:0] bad_ops[3];
    logic [5:0] op;
    int sf, sm, bad;

    legal_ops = '{OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J};
    bad_ops   = '{6'b011111, 6'b000001, 6'b110000};

    vecs.push_back('{6'b000000, 0, 0, 4,  "rtype"});
    vecs.push_back('{6'b100011, 2, 3, 10, "lw_stall"});
    vecs.push_back('{6'b101011, 0, 0, 4,  "sw"});
    vecs.push_back('{6'b000100, 0, 0, 3,  "beq"});
    vecs.push_back('{6'b000010, 0, 0, 3,  "j"});
    vecs.push_back('{6'b001000, 0, 0, 4,  "addi"});
    vecs.push_back('{6'b011111, 0, 0, 3,  "illegal"});
    vecs.push_back('{6'b101011, 1, 2, 7,  "sw_stall"});
    vecs.push_back('{6'b000100, 3, 2, 6,  "beq_stall"});
    vecs.push_back('{6'b100011, 0, 0, 5,  "lw"});

    // Reset held: everything quiet.
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", outvec(), 0);
    chk("reset count", retired_count, 0);
    rst_n = 1'b1;
    #1;
    chk("rst cycle outputs", outvec(), 0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].sf, vecs[i].sm, o);
      verify(vecs[i].name, vecs[i].op, o, vecs[i].exp_cycles);
    end

    // Random instruction stream against the timing rules.
    for (int n = 0; n < 40; n++) begin
      bad = ($urandom_range(0, 6) == 6);
      op = bad ? bad_ops[$urandom_range(0, 2)] : legal_ops[$urandom_range(0, 5)];
      sf = $urandom_range(0, 3);
      sm = $urandom_range(0, 3);
      run_instr(op, sf, sm, o);
      verify("rand", op, o, base_cycles(op) + sf + (is_mem(op) ? sm : 0));
    end

    // Reset during a stalled store: asynchronous clear, then RST, then FETCH.
    opcode = OP_SW;
    mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("memwr stalled memwrite", memwrite, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst memwrite", memwrite, 0);
    chk("async rst count", retired_count, 0);
    chk("async rst outputs", outvec(), 0);
    exp_count = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("post rst RST outputs", outvec(), 0);
    @(posedge clk);
    #1;
    run_instr(OP_RTYPE, 0, 0, o);
    verify("after_rst", OP_RTYPE, o, 4);

    // HALT: terminal, ignores mem_ready, no enables.
    opcode = OP_HALT;
    mem_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("halt entered", halted, 1);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      mem_ready = $urandom_range(0, 1);
      #1;
      if (outvec() !== 19'd1) bad++;
      @(posedge clk);
      #1;
    end
    chk("halt 100 cycles", bad, 0);
    chk("halt count", retired_count, exp_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
